// File: rtl/pipeline_hazard_ctl.sv
// Central stall/flush sequencer for the 5-phase pipeline (IF, ID, EX, MEM, WB).
// Latency: all controls are same-cycle combinational decodes of the registered FSM state and the inputs.
// Backpressure: p4_mem_busy freezes every register; load-use inserts one bubble; HLT parks the front end.
// Optional feature macro: STALL_CNT_EN enables the saturating stall_cnt/flush_cnt counters.
module pipeline_hazard_ctl #(
    parameter int REG_W     = 3,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] p2_rs_a,
    input  logic             p2_use_a,
    input  logic [REG_W-1:0] p2_rs_b,
    input  logic             p2_use_b,
    input  logic             p3_memread,
    input  logic [REG_W-1:0] p3_rd,
    input  logic             p4_br_taken,
    input  logic             p4_mem_busy,
    input  logic             p4_hlt,
    input  logic             resume,
    output logic             pc_en,
    output logic             p1_en,
    output logic             p2_en,
    output logic             p3_en,
    output logic             p4_en,
    output logic             p1_flush,
    output logic             p2_flush,
    output logic             p3_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Bubble count loaded on a taken branch; FLUSH_CYC is limited to 0..3.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC);
    localparam bit         HAS_FLUSH  = (FLUSH_CYC > 0);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] fcnt_q;
    logic [1:0] fcnt_d;

    logic       hit_a;
    logic       hit_b;
    logic       load_use;

    // The load in EX produces its value too late for a dependent op in ID.
    assign hit_a    = p2_use_a && (p2_rs_a == p3_rd);
    assign hit_b    = p2_use_b && (p2_rs_b == p3_rd);
    assign load_use = p3_memread && (hit_a || hit_b);

    // State and bubble counter registers; reset aborts any stall, flush or halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state and control decode, priority rst > mem_busy > branch > hlt > load-use.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        pc_en    = 1'b1;
        p1_en    = 1'b1;
        p2_en    = 1'b1;
        p3_en    = 1'b1;
        p4_en    = 1'b1;
        p1_flush = 1'b0;
        p2_flush = 1'b0;
        p3_flush = 1'b0;
        halted   = 1'b0;

        if (rst) begin
            // Hold everything and fill the front registers with bubbles.
            state_d  = ST_RUN;
            fcnt_d   = 2'd0;
            pc_en    = 1'b0;
            p1_en    = 1'b0;
            p2_en    = 1'b0;
            p3_en    = 1'b0;
            p4_en    = 1'b0;
            p1_flush = 1'b1;
            p2_flush = 1'b1;
            p3_flush = 1'b1;
        end else if (p4_mem_busy) begin
            // Full freeze: nothing moves, no bubbles, FSM holds.
            pc_en  = 1'b0;
            p1_en  = 1'b0;
            p2_en  = 1'b0;
            p3_en  = 1'b0;
            p4_en  = 1'b0;
            halted = (state_q == ST_HALT);
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (p4_br_taken) begin
                        // Kill the three wrong-path ops in IF, ID and EX.
                        p1_flush = 1'b1;
                        p2_flush = 1'b1;
                        p3_flush = 1'b1;
                        if (HAS_FLUSH) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = FLUSH_INIT;
                        end
                    end else if (p4_hlt) begin
                        // Freeze the front end, let HLT drain out of MEM.
                        pc_en    = 1'b0;
                        p1_en    = 1'b0;
                        p2_en    = 1'b0;
                        p3_en    = 1'b0;
                        p3_flush = 1'b1;
                        state_d  = ST_HALT;
                    end else if (load_use) begin
                        // Hold IF/ID one cycle, send a bubble into EX.
                        pc_en    = 1'b0;
                        p1_en    = 1'b0;
                        p2_flush = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Fetch is restarting; discard whatever the I-mem returns.
                    p1_flush = 1'b1;
                    fcnt_d   = fcnt_q - 2'd1;
                    if (fcnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        fcnt_d  = 2'd0;
                    end
                end
                ST_HALT: begin
                    pc_en    = 1'b0;
                    p1_en    = 1'b0;
                    p2_en    = 1'b0;
                    p3_en    = 1'b0;
                    p3_flush = 1'b1;
                    halted   = 1'b1;
                    if (resume) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fcnt_d  = 2'd0;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic br_accept;

    // A branch counts only when it actually redirects the pipeline.
    assign br_accept = (state_q == ST_RUN) && p4_br_taken && !p4_mem_busy;

    // Saturating performance counters; halted and reset cycles are excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && !halted && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (br_accept && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed table-driven bench for pipeline_hazard_ctl (FLUSH_CYC=1).
// Inputs are driven 1 ns after the rising edge and outputs checked on the falling edge.
// Counter checks follow a model built from the expected control vectors.
module tb_pipeline_hazard_ctl;

    localparam int REG_W = 3;
    localparam int CNT_W = 16;

    // Expected control word: {pc_en,p1_en,p2_en,p3_en,p4_en,p1_flush,p2_flush,p3_flush,halted}
    localparam logic [8:0] E_IDLE = 9'b11111_000_0;
    localparam logic [8:0] E_RST  = 9'b00000_111_0;
    localparam logic [8:0] E_BR   = 9'b11111_111_0;
    localparam logic [8:0] E_FL   = 9'b11111_100_0;
    localparam logic [8:0] E_LU   = 9'b00111_010_0;
    localparam logic [8:0] E_FRZ  = 9'b00000_000_0;
    localparam logic [8:0] E_HLT  = 9'b00001_001_0;
    localparam logic [8:0] E_HALT = 9'b00001_001_1;
    localparam logic [8:0] E_HFRZ = 9'b00000_000_1;

    typedef struct {
        logic             rst;
        logic             busy;
        logic             br;
        logic             hlt;
        logic             res;
        logic             mr;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] ra;
        logic             ua;
        logic [REG_W-1:0] rb;
        logic             ub;
        logic [8:0]       exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] p2_rs_a, p2_rs_b, p3_rd;
    logic             p2_use_a, p2_use_b, p3_memread;
    logic             p4_br_taken, p4_mem_busy, p4_hlt, resume;
    logic             pc_en, p1_en, p2_en, p3_en, p4_en;
    logic             p1_flush, p2_flush, p3_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    vec_t tbl[40];
    int   n_vec = 0;
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    pipeline_hazard_ctl #(.REG_W(REG_W), .FLUSH_CYC(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .p2_rs_a(p2_rs_a), .p2_use_a(p2_use_a),
        .p2_rs_b(p2_rs_b), .p2_use_b(p2_use_b),
        .p3_memread(p3_memread), .p3_rd(p3_rd),
        .p4_br_taken(p4_br_taken), .p4_mem_busy(p4_mem_busy),
        .p4_hlt(p4_hlt), .resume(resume),
        .pc_en(pc_en), .p1_en(p1_en), .p2_en(p2_en), .p3_en(p3_en), .p4_en(p4_en),
        .p1_flush(p1_flush), .p2_flush(p2_flush), .p3_flush(p3_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic bsy, input logic b, input logic h,
                                input logic rs, input logic m, input int d, input int a,
                                input logic ua, input int bb, input logic ub, input logic [8:0] e);
        vec_t v;
        v.rst = r; v.busy = bsy; v.br = b; v.hlt = h; v.res = rs; v.mr = m;
        v.rd = REG_W'(d); v.ra = REG_W'(a); v.ua = ua; v.rb = REG_W'(bb); v.ub = ub;
        v.exp = e;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl[n_vec] = v;
        n_vec++;
    endtask

    // One cycle: drive after the edge, check mid-cycle, then advance the counter model.
    task automatic step(input vec_t v, input string name);
        logic [8:0] act;
        @(posedge clk);
        #1;
        rst = v.rst; p4_mem_busy = v.busy; p4_br_taken = v.br; p4_hlt = v.hlt;
        resume = v.res; p3_memread = v.mr; p3_rd = v.rd;
        p2_rs_a = v.ra; p2_use_a = v.ua; p2_rs_b = v.rb; p2_use_b = v.ub;
        @(negedge clk);
        act = {pc_en, p1_en, p2_en, p3_en, p4_en, p1_flush, p2_flush, p3_flush, halted};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s ctl: got %b expected %b", name, act, v.exp);
        end
        checks++;
        if (stall_cnt !== CNT_W'(exp_stall) || flush_cnt !== CNT_W'(exp_flush)) begin
            errors++;
            $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
`ifdef STALL_CNT_EN
        if (v.rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!v.exp[8] && !v.exp[0]) exp_stall++;
            if (v.exp == E_BR) exp_flush++;
        end
`endif
    endtask

    initial begin
        rst = 1'b1; p4_mem_busy = 1'b0; p4_br_taken = 1'b0; p4_hlt = 1'b0; resume = 1'b0;
        p3_memread = 1'b0; p3_rd = '0; p2_rs_a = '0; p2_use_a = 1'b0; p2_rs_b = '0; p2_use_b = 1'b0;

        //     rst bsy br hlt res mr rd ra ua rb ub expected
        add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));   // reset
        add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));  // idle RUN
        add(mk(0, 0, 0, 0, 0, 1, 3, 3, 1, 0, 0, E_LU));    // load-use on rs_a
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));  // single bubble only
        add(mk(0, 0, 0, 0, 0, 1, 3, 3, 0, 5, 1, E_IDLE));  // false hazard
        add(mk(0, 0, 0, 0, 0, 1, 5, 3, 1, 5, 1, E_LU));    // load-use on rs_b
        add(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, 2, 1, E_IDLE));  // match but not a load
        add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_BR));    // taken branch
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FL));    // FLUSH bubble
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));  // back in RUN
        add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_BR));
        add(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ));   // busy during FLUSH
        add(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ));
        add(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ));
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FL));    // FLUSH resumes after busy
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
        add(mk(0, 0, 1, 1, 0, 1, 4, 4, 1, 0, 0, E_BR));    // branch beats hlt and load-use
        add(mk(0, 0, 1, 0, 1, 1, 4, 4, 1, 0, 0, E_FL));    // branch/load-use/resume ignored in FLUSH
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
        add(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ));   // busy beats branch
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));  // branch was not taken
        add(mk(0, 0, 0, 1, 0, 1, 6, 6, 1, 0, 0, E_HLT));   // hlt beats load-use
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT));
        add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT));  // branch ignored in HALT
        add(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_HALT));  // resume pulse
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
        add(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_IDLE));  // resume ignored in RUN
        add(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_HLT));
        add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));   // reset in HALT
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
        add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_BR));
        add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));   // reset in FLUSH
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));

        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // HLT, ten halted cycles (one frozen by mem_busy), resume on the last one.
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_HLT), "hlt_enter");
        for (int k = 0; k < 8; k++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HALT), $sformatf("halt%0d", k));
        end
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_HFRZ), "halt_busy");
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_HALT), "halt_resume");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE), "after_resume");

        // Back-to-back load-use hazards each give exactly one bubble per cycle of match.
        step(mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 7, 1, E_LU), "lu_b2b_0");
        step(mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 7, 1, E_IDLE), "lu_b2b_1");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE), "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
